sound_scheduler: RTL
====================

# sound_scheduler

Arbitrates the game's sound events (wall/self collision, apple eaten, direction keys) onto the single tone-generator channel that drives the audio PWM output. It edge-detects event inputs, applies fixed priority with preemption, and sequences each sound for a programmed duration: a two-step falling melody for death, a single tone otherwise. It sits between the snake/fsm outputs and the audio tone generator. It is clocked from the same 100 MHz clock as the rest of the game logic.

## Interface
Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 1000, duration time base (1 ms unit).
- DUR_KEY, 30, key-click duration in units.
- DUR_APPLE, 150, apple tone duration in units.
- DUR_DIE, 600, total death melody duration in units; must be ≥ 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- hit_wall  in  1  level; rising edge = death event.
- hit_itself  in  1  level; rising edge = death event.
- get_apple  in  1  level; rising edge = apple event.
- up, right, down, left  in  1 each  raw key levels; any rising edge = key event.
- game_status  in  2  00 PAUSED, 01 PLAYING, 10 DIE_FLASHING, 11 INITIALIZING.
- tone_sel  out  3  0 silent, 1 key, 2 apple, 3 die_hi, 4 die_lo.
- tone_en  out  1  high iff tone_sel != 0.
- busy  out  1  high while any sound is playing.
- done  out  1  one-cycle pulse when a sound ends by timeout.

## Operation
- FSM states: IDLE, KEY, APPLE, DIE_HI, DIE_LO. tone_sel encodes the state (IDLE=0 … DIE_LO=4).
- Inputs are registered once. An event is the registered value high while the previous registered value was low.
- Priority: death > apple > key. hit_wall and hit_itself on the same cycle form one death event. Simultaneous events of different class resolve to the higher class only.
- Higher-class event in any state preempts immediately and restarts timing.
- Same-class event: KEY and APPLE restart their duration; death during DIE_HI/DIE_LO is ignored.
- Lower-class event while busy is dropped. No queueing.
- Durations: KEY = DUR_KEY units; APPLE = DUR_APPLE units; DIE_HI = DUR_DIE/2 units (integer divide), then DIE_LO = DUR_DIE − DUR_DIE/2 units, then IDLE.
- Unit = CLK_HZ/TICK_HZ clocks (integer divide).
- The prescaler and unit counter both clear on every sound start, so each segment lasts exactly duration × CLK_HZ/TICK_HZ clocks.
- game_status gating:
  - PAUSED: key events are ignored; apple and death events are accepted.
  - INITIALIZING: all events are ignored, the FSM is forced to IDLE next edge, and done is not pulsed.
  - PLAYING and DIE_FLASHING: all events are accepted.
- done pulses on the KEY→IDLE, APPLE→IDLE and DIE_LO→IDLE timeouts only. It does not pulse on DIE_HI→DIE_LO or on preemption.

## Timing
- Reset (reset=0 at an edge) puts every output to 0 and the state to IDLE at that edge, mid-sound included. Input history registers clear, so an input already high after reset is taken as a new event.
- Latency: an input first sampled high at edge k sets tone_sel at edge k+2.
- Segment length is exact. With N = duration × CLK_HZ/TICK_HZ, tone_sel holds for N clocks, then changes at the next edge. done is high during the first cycle of IDLE.
- Preemption or restart at edge e starts a fresh N-clock segment from edge e.
- Counters are sized by $clog2 of maximum duration and CLK_HZ/TICK_HZ. No wrap is reachable.

## Configuration
- SOUND_KEY_CLICK_EN defined: key events are played as described.
- SOUND_KEY_CLICK_EN undefined: the up/right/down/left ports remain but are ignored, tone_sel never equals 1, and the KEY state logic is removed.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100 (10 clocks/unit), DUR_KEY=2, DUR_APPLE=3, DUR_DIE=5, game_status=01.
- Apple rise at edge k → tone_sel=2 from edge k+2 for 30 clocks, then 0, with done=1 for 1 cycle and busy=0.
- hit_wall rise → tone_sel=3 for 20 clocks, then 4 for 30 clocks, then 0; a second hit_itself edge during DIE_HI does not change timing.
- Key edge, then get_apple edge 5 clocks later → tone_sel goes 1 → 2, and 2 holds a full 30 clocks; no done pulse at the preemption.
- During APPLE, a key edge → ignored; a second apple edge at 20 clocks in → APPLE restarts, total 50 clocks of tone_sel=2.
- hit_wall and get_apple rise on the same clock → die melody only. Separately: game_status=00 with a key edge → silent; reset=0 mid-APPLE → tone_sel=0 at that edge.
- Built without SOUND_KEY_CLICK_EN: repeated key edges → tone_sel stays 0, busy stays 0.

Source files
------------

// File: rtl/sound_if.sv
// Event/tone bundle between the game logic and sound_scheduler.
// master: game side (drives events, reads tone state); slave: scheduler.
interface sound_if;
  logic       hit_wall;
  logic       hit_itself;
  logic       get_apple;
  logic       up;
  logic       right;
  logic       down;
  logic       left;
  logic [1:0] game_status;
  logic [2:0] tone_sel;
  logic       tone_en;
  logic       busy;
  logic       done;

  modport master (
    output hit_wall, hit_itself, get_apple, up, right, down, left, game_status,
    input  tone_sel, tone_en, busy, done
  );

  modport slave (
    input  hit_wall, hit_itself, get_apple, up, right, down, left, game_status,
    output tone_sel, tone_en, busy, done
  );
endinterface

// File: rtl/sound_scheduler.sv
// sound_scheduler: edge-detects game sound events, resolves them by fixed
// priority (death > apple > key) with preemption, and times each sound on
// the single tone channel. Death plays a two-step falling melody.
// Build option: define SOUND_KEY_CLICK_EN to play key clicks; without it the
// direction keys are ignored and the KEY state is never entered.
module sound_scheduler #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int DUR_KEY   = 30,
  parameter int DUR_APPLE = 150,
  parameter int DUR_DIE   = 600
) (
  input  logic    clock,
  input  logic    reset,
  sound_if.slave  bus
);

  localparam int UNIT    = CLK_HZ / TICK_HZ;
  localparam int DUR_HI  = DUR_DIE / 2;
  localparam int DUR_LO  = DUR_DIE - DUR_HI;
  localparam int DUR_MX0 = (DUR_KEY > DUR_APPLE) ? DUR_KEY : DUR_APPLE;
  localparam int DUR_MAX = (DUR_MX0 > DUR_LO) ? DUR_MX0 : DUR_LO;
  localparam int PW      = (UNIT > 1) ? $clog2(UNIT) : 1;
  localparam int UW      = $clog2(DUR_MAX + 1);

  localparam logic [1:0] GS_INIT = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEY    = 3'd1,
    APPLE  = 3'd2,
    DIE_HI = 3'd3,
    DIE_LO = 3'd4
  } state_t;

  state_t        state, nxt;
  logic [2:0]    in_q, in_p;     // {get_apple, hit_itself, hit_wall}
  logic [1:0]    gs_q;
  logic          death_ev, apple_ev;
  logic [PW-1:0] pre_cnt;
  logic [UW-1:0] unit_cnt, seg_len;
  logic          unit_end, timeout, start, done_nxt, die, done_q;

`ifdef SOUND_KEY_CLICK_EN
  localparam logic [1:0] GS_PAUSED = 2'b00;
  logic [3:0] key_q, key_p;
  logic       key_ev;

  // key input history for edge detection
  always_ff @(posedge clock) begin
    if (!reset) begin
      key_q  <= '0;
      key_p  <= '0;
      key_ev <= 1'b0;
    end else begin
      key_q  <= {bus.left, bus.down, bus.right, bus.up};
      key_p  <= key_q;
      key_ev <= |(key_q & ~key_p);
    end
  end
`else
  logic unused_keys;
  assign unused_keys = ^{bus.up, bus.right, bus.down, bus.left};
`endif

  // input history and registered events; the event register is the second
  // stage that gives the two-edge input-to-tone latency
  always_ff @(posedge clock) begin
    if (!reset) begin
      in_q     <= '0;
      in_p     <= '0;
      gs_q     <= '0;
      death_ev <= 1'b0;
      apple_ev <= 1'b0;
    end else begin
      in_q     <= {bus.get_apple, bus.hit_itself, bus.hit_wall};
      in_p     <= in_q;
      gs_q     <= bus.game_status;
      death_ev <= |(in_q[1:0] & ~in_p[1:0]);
      apple_ev <= in_q[2] & ~in_p[2];
    end
  end

  // duration of the segment currently playing, in units
  always_comb begin
    seg_len = '0;
    case (state)
`ifdef SOUND_KEY_CLICK_EN
      KEY:     seg_len = UW'(DUR_KEY);
`endif
      APPLE:   seg_len = UW'(DUR_APPLE);
      DIE_HI:  seg_len = UW'(DUR_HI);
      DIE_LO:  seg_len = UW'(DUR_LO);
      default: seg_len = '0;
    endcase
  end

  assign die      = (state == DIE_HI) || (state == DIE_LO);
  assign unit_end = (pre_cnt == PW'(UNIT - 1));
  assign timeout  = (state != IDLE) && unit_end && (unit_cnt == seg_len - UW'(1));

  // next state: init override, then priority with preemption, then timeout
  always_comb begin
    nxt      = state;
    start    = 1'b0;
    done_nxt = 1'b0;
    if (gs_q == GS_INIT) begin
      nxt = IDLE;
    end else if (death_ev && !die) begin
      nxt   = DIE_HI;
      start = 1'b1;
    end else if (apple_ev && !die) begin
      nxt   = APPLE;
      start = 1'b1;
`ifdef SOUND_KEY_CLICK_EN
    end else if (key_ev && (gs_q != GS_PAUSED) && ((state == IDLE) || (state == KEY))) begin
      nxt   = KEY;
      start = 1'b1;
`endif
    end else if (timeout) begin
      if (state == DIE_HI) begin
        nxt = DIE_LO;
      end else begin
        nxt      = IDLE;
        done_nxt = 1'b1;
      end
    end
  end

  // state and done pulse registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      done_q <= done_nxt;
    end
  end

  // prescaler + unit counter, restarted at every segment boundary
  always_ff @(posedge clock) begin
    if (!reset) begin
      pre_cnt  <= '0;
      unit_cnt <= '0;
    end else if (start || timeout || (state == IDLE) || (gs_q == GS_INIT)) begin
      pre_cnt  <= '0;
      unit_cnt <= '0;
    end else if (unit_end) begin
      pre_cnt  <= '0;
      unit_cnt <= unit_cnt + UW'(1);
    end else begin
      pre_cnt  <= pre_cnt + PW'(1);
    end
  end

  assign bus.tone_sel = state;
  assign bus.tone_en  = (state != IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;

endmodule
